// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_unit
//  Brief    : Pipeline stall/flush controller with memory-wait watchdog and
//             saturating stall/flush performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_uses_rs2,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clear_err,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_write_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_write_en,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int               C_WC_W      = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [C_WC_W-1:0] C_WAIT_LAST = C_WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t             r_state;
    logic [C_WC_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic w_lu;
    logic w_ms;
    logic w_in_halt;
    logic w_pc_we;
    logic w_if_id_we;
    logic w_if_id_flush;
    logic w_id_ex_we;
    logic w_id_ex_bubble;
    logic w_ex_mem_we;
    logic w_mem_wb_bubble;

    assign w_lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                  ((id_ex_rd == if_id_rs1) ||
                   (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
    assign w_ms      = mem_req && !mem_ready;
    assign w_in_halt = (r_state == S_HALT);

    // Priority decode: HALT > memory stall > taken branch > load-use > normal.
    always_comb begin
        w_pc_we         = 1'b1;
        w_if_id_we      = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_we      = 1'b1;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_we     = 1'b1;
        w_mem_wb_bubble = 1'b0;
        if (w_in_halt) begin
            w_pc_we         = 1'b0;
            w_if_id_we      = 1'b0;
            w_id_ex_we      = 1'b0;
            w_ex_mem_we     = 1'b0;
            w_mem_wb_bubble = 1'b1;
        end else if (w_ms) begin
            w_pc_we         = 1'b0;
            w_if_id_we      = 1'b0;
            w_id_ex_we      = 1'b0;
            w_ex_mem_we     = 1'b0;
            w_mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            w_if_id_flush   = 1'b1;
            w_id_ex_bubble  = 1'b1;
        end else if (w_lu) begin
            w_pc_we         = 1'b0;
            w_if_id_we      = 1'b0;
            w_id_ex_bubble  = 1'b1;
        end
    end

    // Outputs are held low for the whole time reset is asserted.
    assign pc_write_en     = arst_n & w_pc_we;
    assign if_id_write_en  = arst_n & w_if_id_we;
    assign if_id_flush     = arst_n & w_if_id_flush;
    assign id_ex_write_en  = arst_n & w_id_ex_we;
    assign id_ex_bubble    = arst_n & w_id_ex_bubble;
    assign ex_mem_write_en = arst_n & w_ex_mem_we;
    assign mem_wb_bubble   = arst_n & w_mem_wb_bubble;
    assign halted          = arst_n & w_in_halt;
    assign stall_cycles    = r_stall_cnt;
    assign flush_count     = r_flush_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_ms) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= C_WC_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (!w_ms) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == C_WAIT_LAST) begin
                        r_state    <= S_HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + C_WC_W'(1);
                    end
                end
                S_HALT: begin
                    if (clear_err) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_we && !w_in_halt && (r_stall_cnt != C_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_if_id_flush && (r_flush_cnt != C_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall and flush controller for the 5-stage pipeline, the counterpart of the forwarding logic. Forwarding resolves RAW hazards by bypassing; this block resolves the hazards forwarding cannot cover: load-use, data-memory wait states and taken-branch squash. It freezes stages and injects bubbles. It also runs a data-memory timeout watchdog and saturating stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 255: consecutive not-ready memory cycles that trigger a halt (≥2).
- CNT_W, 16: width of the performance counters.

- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous reset, active low
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination register of the instruction in EX
- if_id_rs1  in  5  rs1 of the instruction in ID
- if_id_rs2  in  5  rs2 of the instruction in ID
- if_id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch)
- branch_taken  in  1  branch/jump resolved taken in EX
- mem_req  in  1  MEM stage holds a load or store
- mem_ready  in  1  data memory completes the access this cycle
- clear_err  in  1  leave HALT
- pc_write_en  out  1  PC register enable
- if_id_write_en  out  1  IF/ID register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_write_en  out  1  ID/EX register enable
- id_ex_bubble  out  1  load NOP (control bits zero) into ID/EX
- ex_mem_write_en  out  1  EX/MEM register enable
- mem_wb_bubble  out  1  load NOP into MEM/WB
- halted  out  1  watchdog fired; pipeline frozen
- stall_cycles  out  CNT_W  cycles with pc_write_en=0, excluding HALT; saturating
- flush_count  out  CNT_W  taken-branch flushes; saturating

## Operation
- lu = id_ex_mem_read && id_ex_rd!=0 && (id_ex_rd==if_id_rs1 || (if_id_uses_rs2 && id_ex_rd==if_id_rs2)).
- ms = mem_req && !mem_ready.
- States: RUN, MEM_WAIT, HALT. Internal wait_cnt has width clog2(MEM_TIMEOUT)+1.
- Output priority is HALT > ms > branch_taken > lu > normal. Outputs are combinational from state and inputs.
  - HALT: all *_write_en=0, if_id_flush=0, id_ex_bubble=0, mem_wb_bubble=1, halted=1.
  - ms (RUN or MEM_WAIT): pc/if_id/id_ex/ex_mem write_en=0, mem_wb_bubble=1, flush and bubble 0.
  - branch_taken: all write_en=1, if_id_flush=1, id_ex_bubble=1. lu is ignored because the ID instruction is squashed.
  - lu: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, id_ex_write_en=1, ex_mem_write_en=1.
  - Normal: all write_en=1, all flush/bubble/halted=0.
- Transitions:
  - RUN → MEM_WAIT on ms, with wait_cnt←1.
  - MEM_WAIT: if !ms, go to RUN with wait_cnt←0.
  - MEM_WAIT: else if wait_cnt==MEM_TIMEOUT-1, go to HALT.
  - MEM_WAIT: else wait_cnt+1.
  - HALT → RUN only when clear_err=1, with wait_cnt←0. mem_ready and all other inputs are ignored in HALT.
- Result: MEM_TIMEOUT consecutive ms cycles put the block in HALT on the following edge.
- branch_taken while ms: the EX stage is frozen, so the branch stays asserted. The flush is taken on the first cycle ms clears. No flush is recorded during the wait.
- Counters:
  - stall_cycles +1 on each edge where pc_write_en=0 and state≠HALT.
  - flush_count +1 on each edge where if_id_flush=1.
  - Both saturate at 2^CNT_W−1.

## Timing
- Reset (arst_n=0, asynchronous): state=RUN, wait_cnt=0, counters=0.
- While arst_n=0, all outputs are forced to 0: every write_en, flush, bubble and halted are 0, and the counters read 0.
- After release, outputs follow the decode above on the same cycle.
- Control outputs have zero-cycle latency: they are combinational from inputs in the same cycle. The state register only affects outputs in HALT. halted asserts on the cycle after the last timeout cycle.
- Load-use costs exactly 1 stall cycle. The next cycle the load has moved to MEM and lu deasserts naturally.
- A memory wait costs N stall cycles for N consecutive not-ready cycles (N<MEM_TIMEOUT).
- Reset asserted mid-wait or in HALT returns to RUN immediately.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5, uses_rs2=1 for 1 cycle → pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, stall_cycles=1. Repeat with uses_rs2=0 → no stall. Repeat with rd=0 → no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready → 3 cycles with all enables 0 and mem_wb_bubble=1; state back to RUN; stall_cycles=3.
- Priority: branch_taken=1 together with lu=1 → if_id_flush=1, id_ex_bubble=1, pc_write_en=1, flush_count=1. Add ms → only the freeze applies; the flush occurs on the cycle after ready.
- Timeout with MEM_TIMEOUT=4: ms held → halted=1 after the 4th cycle. A later mem_ready has no effect; clear_err=1 → RUN, halted=0.
- Saturation with CNT_W=3: 10 flushes → flush_count=7.
- Reset mid-MEM_WAIT: drop arst_n → outputs 0, counters 0. After release, state is RUN.
